// File: rtl/edge_capture_bank_pkg.sv
// Shared constants and helpers for the edge capture bank.
package edge_capture_bank_pkg;

    // Edge qualification modes; one mode applies to every channel of a bank.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Ceiling log2 with a floor of 1, so a single-channel bank still has a select bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_capture_chan.sv
// One capture channel: strobe synchroniser, edge detect, held word,
// saturating event counter, overrun flag and pending flag.
module edge_capture_chan
    import edge_capture_bank_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic              evt,
    output logic [DATA_W-1:0] hold,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   hit;

    // Synchronise the strobe and register the qualified edge as a one-cycle event.
    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
            last_q <= sync_q[SYNC_STAGES-1];
            evt    <= hit;
        end
    end

    // Compare the newest synchronised level against the previous one.
    // NOTE: hit gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        hit = 1'b0;
        case (EDGE_MODE)
            EDGE_FALL: hit = ~sync_q[SYNC_STAGES-1] & last_q;
            EDGE_BOTH: hit = sync_q[SYNC_STAGES-1] ^ last_q;
            default:   hit = sync_q[SYNC_STAGES-1] & ~last_q;
        endcase
    end

    // Capture on event; a read clear in the same cycle restarts the tally at one.
    // NOTE: hold is ordinary flops, not a RAM, so it is reset along with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            pending <= 1'b0;
        end else if (evt) begin
            hold    <= data;
            pending <= 1'b1;
            if (clear) begin
                count <= CNT_W'(1);
                ovf   <= 1'b0;
            end else begin
                count <= (count == '1) ? count : count + CNT_W'(1);
                ovf   <= pending;
            end
        end else if (clear) begin
            count   <= '0;
            ovf     <= 1'b0;
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_capture_bank.sv
// Multi-channel edge capture bank with a single-request read port.
// A read returns the channel state from before the request clock and
// clears that channel's count, overrun and pending flags.
module edge_capture_bank
    import edge_capture_bank_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_in,
    input  logic [NUM_CH*DATA_W-1:0]     ch_data,
    input  logic                         rd_req,
    input  logic [clog2_min1(NUM_CH)-1:0] rd_sel,
    output logic                         rd_ack,
    output logic [DATA_W-1:0]            rd_data,
    output logic [CNT_W-1:0]             rd_count,
    output logic                         rd_ovf,
    output logic [NUM_CH-1:0]            pending,
    output logic                         irq
);

    localparam int SEL_W = clog2_min1(NUM_CH);

    logic [DATA_W-1:0] hold_arr [NUM_CH];
    logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
    logic [NUM_CH-1:0] ovf_vec;
    logic [NUM_CH-1:0] clr;
    // Event strobes are consumed inside each channel; the bank has no use for them.
    logic [NUM_CH-1:0] evt_unused;
    logic              sel_ok;

    assign sel_ok = (int'(rd_sel) < NUM_CH);
    assign irq    = |pending;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign clr[gi] = rd_req && (rd_sel == SEL_W'(gi));

        edge_capture_chan #(
            .DATA_W      (DATA_W),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .strobe  (ch_in[gi]),
            .data    (ch_data[gi*DATA_W +: DATA_W]),
            .clear   (clr[gi]),
            .evt     (evt_unused[gi]),
            .hold    (hold_arr[gi]),
            .count   (cnt_arr[gi]),
            .ovf     (ovf_vec[gi]),
            .pending (pending[gi])
        );
    end

    // Register the read response; the payload is zero unless a valid channel is acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            rd_count <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_ack   <= rd_req;
            rd_data  <= '0;
            rd_count <= '0;
            rd_ovf   <= 1'b0;
            if (rd_req && sel_ok) begin
                rd_data  <= hold_arr[rd_sel];
                rd_count <= cnt_arr[rd_sel];
                rd_ovf   <= ovf_vec[rd_sel];
            end
        end
    end

endmodule
